// File: rtl/tcdm_cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_cache_arb_pkg
// Description : Shared types, constants and helpers for the TCDM-to-cache
//               arbiter. Default type widths match the default configuration
//               (4 masters, 2 outstanding requests).
// Revision    : 1.0 - initial release
// ============================================================================
package tcdm_cache_arb_pkg;

    localparam int unsigned PERF_CNT_WIDTH      = 32;
    localparam int unsigned DEF_NR_MASTER_PORTS = 4;
    localparam int unsigned DEF_MAX_OUTSTANDING = 2;
    localparam int unsigned DEF_IDX_WIDTH       = (DEF_NR_MASTER_PORTS > 1) ? $clog2(DEF_NR_MASTER_PORTS) : 1;
    localparam int unsigned DEF_CNT_WIDTH       = $clog2(DEF_MAX_OUTSTANDING + 1);

    typedef logic [DEF_IDX_WIDTH-1:0] idx_t;
    typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin successor of idx among n channels.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_cache_arb_idx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_cache_arb_idx_fifo
// Description : Small synchronous FIFO holding the master index of every
//               in-flight request, so responses can be routed in order.
//               Push while full and pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_cache_arb_idx_fifo
    import tcdm_cache_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_usage;
    logic              w_do_push;
    logic              w_do_pop;

    assign full_o    = (r_usage == CNT_W'(DEPTH));
    assign empty_o   = (r_usage == '0);
    assign usage_o   = r_usage;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave usage unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_usage <= r_usage + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_usage <= r_usage - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcdm_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_cache_arbiter
// Description : N-to-1 round-robin front-end between TCDM masters and one
//               data-cache core port. The winner is locked while the cache
//               stalls, and an in-order index FIFO routes responses back.
//               Optional per-master stall counters: TCDM_CACHE_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_cache_arbiter
    import tcdm_cache_arb_pkg::*;
#(
    parameter int unsigned NR_MASTER_PORTS = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NR_MASTER_PORTS-1:0]                mst_req_i,
    output logic [NR_MASTER_PORTS-1:0]                mst_gnt_o,
    input  logic [NR_MASTER_PORTS-1:0]                mst_we_i,
    input  logic [NR_MASTER_PORTS*DATA_WIDTH/8-1:0]   mst_be_i,
    input  logic [NR_MASTER_PORTS*ADDR_WIDTH-1:0]     mst_addr_i,
    input  logic [NR_MASTER_PORTS*DATA_WIDTH-1:0]     mst_wdata_i,
    output logic [NR_MASTER_PORTS-1:0]                mst_rvalid_o,
    output logic [NR_MASTER_PORTS*DATA_WIDTH-1:0]     mst_rdata_o,
    output logic [NR_MASTER_PORTS-1:0]                mst_err_o,
    output logic                                      cache_req_o,
    input  logic                                      cache_gnt_i,
    output logic                                      cache_we_o,
    output logic [DATA_WIDTH/8-1:0]                   cache_be_o,
    output logic [ADDR_WIDTH-1:0]                     cache_addr_o,
    output logic [DATA_WIDTH-1:0]                     cache_wdata_o,
    input  logic                                      cache_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                     cache_rdata_i,
    input  logic                                      cache_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding_o
`ifdef TCDM_CACHE_ARB_PERF_EN
    ,
    input  logic                                      perf_clear_i,
    output logic [NR_MASTER_PORTS*PERF_CNT_WIDTH-1:0] perf_stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = idx_width(NR_MASTER_PORTS);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;

    typedef logic [IDX_W-1:0] sel_t;

    sel_t r_rr_ptr;
    logic r_locked;
    sel_t r_lock_idx;
    sel_t w_rr_winner;
    logic w_rr_found;
    logic w_lock_hit;
    sel_t w_sel;
    logic w_valid;
    logic w_cache_req;
    logic w_handshake;
    logic w_fifo_full;
    logic w_fifo_empty;
    sel_t w_fifo_head;
    logic w_resp_valid;

    // Round-robin search: first requester at or after the pointer, wrapping;
    // a locked winner that still requests overrides the search.
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_lock_hit  = 1'b0;
        for (int k = 0; k < int'(NR_MASTER_PORTS); k++) begin
            for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
                if (!w_rr_found && mst_req_i[i] &&
                    (i == ((int'(r_rr_ptr) + k) % int'(NR_MASTER_PORTS)))) begin
                    w_rr_found  = 1'b1;
                    w_rr_winner = sel_t'(i);
                end
            end
        end
        for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
            if (r_locked && (r_lock_idx == sel_t'(i)) && mst_req_i[i]) begin
                w_lock_hit = 1'b1;
            end
        end
        w_sel   = w_lock_hit ? r_lock_idx : w_rr_winner;
        w_valid = w_lock_hit || w_rr_found;
    end

    // A full FIFO blocks new requests regardless of a same-cycle response,
    // which keeps rvalid off the request path.
    assign w_cache_req  = (|mst_req_i) && !w_fifo_full;
    assign w_handshake  = w_cache_req && cache_gnt_i;
    assign cache_req_o  = w_cache_req;
    assign w_resp_valid = cache_rvalid_i && !w_fifo_empty;

    // Payload mux from the winner; zero when nobody requests.
    always_comb begin
        cache_we_o    = 1'b0;
        cache_be_o    = '0;
        cache_addr_o  = '0;
        cache_wdata_o = '0;
        for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
            if (w_valid && (w_sel == sel_t'(i))) begin
                cache_we_o    = mst_we_i[i];
                cache_be_o    = mst_be_i[i*BE_W +: BE_W];
                cache_addr_o  = mst_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                cache_wdata_o = mst_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Per-master grant and response steering.
    always_comb begin
        mst_gnt_o    = '0;
        mst_rvalid_o = '0;
        for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
            mst_gnt_o[i]    = w_handshake && w_valid && (w_sel == sel_t'(i));
            mst_rvalid_o[i] = w_resp_valid && (w_fifo_head == sel_t'(i));
        end
    end

    // Response data and error are shared by all masters; dropped responses
    // do not leak onto the outputs.
    assign mst_rdata_o = w_resp_valid ? {NR_MASTER_PORTS{cache_rdata_i}} : '0;
    assign mst_err_o   = {NR_MASTER_PORTS{w_resp_valid && cache_err_i}};

    // Pointer advance on handshake; lock the winner while the cache stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_handshake) begin
            r_rr_ptr <= sel_t'(rr_next(32'(w_sel), NR_MASTER_PORTS));
            r_locked <= 1'b0;
        end else if (w_cache_req) begin
            r_locked   <= 1'b1;
            r_lock_idx <= w_sel;
        end
    end

    tcdm_cache_arb_idx_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (IDX_W)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_handshake),
        .data_i  (w_sel),
        .pop_i   (cache_rvalid_i),
        .data_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .usage_o (outstanding_o)
    );

`ifdef TCDM_CACHE_ARB_PERF_EN
    generate
        for (genvar g = 0; g < int'(NR_MASTER_PORTS); g++) begin : g_perf_cnt
            logic [PERF_CNT_WIDTH-1:0] r_stall_cnt;

            // Saturating stall counter; clear wins over increment.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_stall_cnt <= '0;
                end else if (perf_clear_i) begin
                    r_stall_cnt <= '0;
                end else if (mst_req_i[g] && !mst_gnt_o[g] && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + PERF_CNT_WIDTH'(1);
                end
            end

            assign perf_stall_cnt_o[g*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = r_stall_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_cache_arbiter
// Description : Self-checking bench for tcdm_cache_arbiter. Expected grants
//               are queued by each test; every handshake queues the expected
//               response (master, data) which is compared when rvalid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_cache_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    typedef struct {
        int          mst;
        logic [31:0] data;
    } sb_t;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic [N-1:0]         mst_req_i;
    logic [N-1:0]         mst_gnt_o;
    logic [N-1:0]         mst_we_i;
    logic [N*DW/8-1:0]    mst_be_i;
    logic [N*AW-1:0]      mst_addr_i;
    logic [N*DW-1:0]      mst_wdata_i;
    logic [N-1:0]         mst_rvalid_o;
    logic [N*DW-1:0]      mst_rdata_o;
    logic [N-1:0]         mst_err_o;
    logic                 cache_req_o;
    logic                 cache_gnt_i;
    logic                 cache_we_o;
    logic [DW/8-1:0]      cache_be_o;
    logic [AW-1:0]        cache_addr_o;
    logic [DW-1:0]        cache_wdata_o;
    logic                 cache_rvalid_i;
    logic [DW-1:0]        cache_rdata_i;
    logic                 cache_err_i;
    logic [$clog2(MO+1)-1:0] outstanding_o;
`ifdef TCDM_CACHE_ARB_PERF_EN
    logic                 perf_clear_i;
    logic [N*32-1:0]      perf_stall_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_proto  = 0;
    int          exp_gnt_q[$];
    sb_t         sb_q[$];
    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    tcdm_cache_arbiter #(
        .NR_MASTER_PORTS (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .mst_req_i        (mst_req_i),
        .mst_gnt_o        (mst_gnt_o),
        .mst_we_i         (mst_we_i),
        .mst_be_i         (mst_be_i),
        .mst_addr_i       (mst_addr_i),
        .mst_wdata_i      (mst_wdata_i),
        .mst_rvalid_o     (mst_rvalid_o),
        .mst_rdata_o      (mst_rdata_o),
        .mst_err_o        (mst_err_o),
        .cache_req_o      (cache_req_o),
        .cache_gnt_i      (cache_gnt_i),
        .cache_we_o       (cache_we_o),
        .cache_be_o       (cache_be_o),
        .cache_addr_o     (cache_addr_o),
        .cache_wdata_o    (cache_wdata_o),
        .cache_rvalid_i   (cache_rvalid_i),
        .cache_rdata_i    (cache_rdata_i),
        .cache_err_i      (cache_err_i),
        .outstanding_o    (outstanding_o)
`ifdef TCDM_CACHE_ARB_PERF_EN
        ,
        .perf_clear_i     (perf_clear_i),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    function automatic logic [31:0] addr_of(input int m);
        return 32'h1000 + 32'(m) * 32'h100;
    endfunction

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return a ^ 32'hDEADAEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Protocol monitor: responses with nothing in flight are counted.
    always @(negedge clk) begin
        if (rst_ni && cache_rvalid_i && (outstanding_o == '0)) begin
            n_proto++;
            $display("note: protocol violation, rvalid with empty FIFO at %0t", $time);
        end
    end

    // Drive a one-cycle cache response for the oldest pending request.
    task automatic respond();
        logic [31:0] a;
        a = (pend_q.size() > 0) ? pend_q.pop_front() : 32'h0;
        cache_rvalid_i = 1'b1;
        cache_rdata_i  = rsp_of(a);
    endtask

    // One clock: scoreboard checks at the falling edge, then past the rising edge.
    task automatic cycle();
        sb_t         e;
        logic [3:0]  oh;
        int          m;
        @(negedge clk);
        if (cache_rvalid_i) begin
            if (sb_q.size() == 0) begin
                check_eq("drop_rvalid", 64'(mst_rvalid_o), 64'h0);
            end else begin
                e  = sb_q.pop_front();
                oh = 4'b0001 << e.mst;
                check_eq("rvalid", 64'(mst_rvalid_o), 64'(oh));
                check_eq("rdata", 64'(mst_rdata_o[e.mst*DW +: DW]), 64'(e.data));
            end
        end
        if (cache_req_o && cache_gnt_i) begin
            if (exp_gnt_q.size() == 0) begin
                check_eq("unexp_gnt", 64'(mst_gnt_o), 64'h0);
            end else begin
                m  = exp_gnt_q.pop_front();
                oh = 4'b0001 << m;
                check_eq("gnt", 64'(mst_gnt_o), 64'(oh));
                check_eq("gnt_addr", 64'(cache_addr_o), 64'(addr_of(m)));
                pend_q.push_back(addr_of(m));
                sb_q.push_back('{mst: m, data: rsp_of(addr_of(m))});
            end
        end
        @(posedge clk);
        #1;
        cache_rvalid_i = 1'b0;
        cache_err_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        mst_req_i      = '0;
        cache_gnt_i    = 1'b0;
        cache_rvalid_i = 1'b0;
        cache_err_i    = 1'b0;
        cache_rdata_i  = '0;
`ifdef TCDM_CACHE_ARB_PERF_EN
        perf_clear_i   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_gnt_q.delete();
        sb_q.delete();
        pend_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mst_we_i = '0;
        for (int m = 0; m < N; m++) begin
            mst_addr_i[m*AW +: AW]    = addr_of(m);
            mst_be_i[m*4 +: 4]        = 4'hF;
            mst_wdata_i[m*DW +: DW]   = 32'hA000_0000 + 32'(m);
        end

        // Reset state
        do_reset();
        #1;
        check_eq("rst_req", 64'(cache_req_o), 64'h0);
        check_eq("rst_gnt", 64'(mst_gnt_o), 64'h0);
        check_eq("rst_outst", 64'(outstanding_o), 64'h0);
        check_eq("rst_addr", 64'(cache_addr_o), 64'h0);
        check_eq("rst_rdata", 64'(mst_rdata_o), 64'h0);

        // Single read from master 0, response two cycles after grant
        mst_req_i = 4'b0001; cache_gnt_i = 1'b1; exp_gnt_q.push_back(0);
        cycle();
        mst_req_i = 4'b0000; cache_gnt_i = 1'b0;
        check_eq("t1_outst1", 64'(outstanding_o), 64'h1);
        cycle();
        respond(); cache_err_i = 1'b1;
        #1;
        check_eq("t1_rvalid", 64'(mst_rvalid_o), 64'h1);
        check_eq("t1_rdata", 64'(mst_rdata_o[DW-1:0]), 64'hDEADBEEF);
        check_eq("t1_err", 64'(mst_err_o), 64'hF);
        cycle();
        check_eq("t1_outst0", 64'(outstanding_o), 64'h0);

        // All masters request; order 0,1,2,3,0 with 1-cycle responses
        do_reset();
        mst_req_i = 4'b1111; cache_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt_q.push_back(k % 4);
            if (pend_q.size() > 0) respond();
            cycle();
        end
        mst_req_i = 4'b0000; cache_gnt_i = 1'b0;
        respond();
        cycle();
        check_eq("t2_outst", 64'(outstanding_o), 64'h0);
        check_eq("t2_sb_empty", 64'(sb_q.size()), 64'h0);

        // Lock-in: master 2 stalls, master 0 arrives but must wait
        do_reset();
        mst_req_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) mst_req_i = 4'b0101;
            #1;
            check_eq("t3_lock_addr", 64'(cache_addr_o), 64'(addr_of(2)));
            check_eq("t3_no_gnt", 64'(mst_gnt_o), 64'h0);
            cycle();
        end
        cache_gnt_i = 1'b1; exp_gnt_q.push_back(2);
        cycle();
        exp_gnt_q.push_back(0);
        cycle();
        mst_req_i = 4'b0000; cache_gnt_i = 1'b0;
        respond(); cycle();
        respond(); cycle();
        check_eq("t3_outst", 64'(outstanding_o), 64'h0);

        // Outstanding limit and no same-cycle unblock
        do_reset();
        mst_req_i = 4'b0010; cache_gnt_i = 1'b1;
        exp_gnt_q.push_back(1); cycle();
        exp_gnt_q.push_back(1); cycle();
        #1;
        check_eq("t4_req_full", 64'(cache_req_o), 64'h0);
        check_eq("t4_outst2", 64'(outstanding_o), 64'h2);
        check_eq("t4_gnt_full", 64'(mst_gnt_o), 64'h0);
        cycle();
        respond();
        #1;
        check_eq("t4_req_pop", 64'(cache_req_o), 64'h0);
        cycle();
        check_eq("t4_req_again", 64'(cache_req_o), 64'h1);
        exp_gnt_q.push_back(1); cycle();
        mst_req_i = 4'b0000; cache_gnt_i = 1'b0;
        respond(); cycle();
        respond(); cycle();
        check_eq("t4_outst0", 64'(outstanding_o), 64'h0);

        // Spurious response with empty FIFO
        do_reset();
        cache_rvalid_i = 1'b1; cache_rdata_i = 32'h1234_5678;
        #1;
        check_eq("t5_rvalid", 64'(mst_rvalid_o), 64'h0);
        cycle();
        check_eq("t5_outst", 64'(outstanding_o), 64'h0);

        // Reset with two requests in flight; stale response dropped
        do_reset();
        mst_req_i = 4'b0011; cache_gnt_i = 1'b1;
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
        cycle(); cycle();
        check_eq("t6_outst2", 64'(outstanding_o), 64'h2);
        mst_req_i = 4'b0000; cache_gnt_i = 1'b0;
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
        check_eq("t6_outst_rst", 64'(outstanding_o), 64'h0);
        sb_q.delete();
        respond();
        cycle();
        check_eq("t6_outst_stale", 64'(outstanding_o), 64'h0);
        mst_req_i = 4'b1010;
        #1;
        check_eq("t6_rr_ptr0", 64'(cache_addr_o), 64'(addr_of(1)));
        mst_req_i = 4'b0000;
        check_eq("proto_count", 64'(n_proto), 64'h2);

`ifdef TCDM_CACHE_ARB_PERF_EN
        // Stall counter and clear
        do_reset();
        mst_req_i = 4'b0010;
        repeat (5) cycle();
        mst_req_i = 4'b0000;
        check_eq("perf_cnt1", 64'(perf_stall_cnt_o[63:32]), 64'h5);
        check_eq("perf_cnt0", 64'(perf_stall_cnt_o[31:0]), 64'h0);
        perf_clear_i = 1'b1;
        cycle();
        perf_clear_i = 1'b0;
        check_eq("perf_clear", 64'(perf_stall_cnt_o[63:32]), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
